seq_alu: RTL and testbench

- Parametrised, registered successor to the 8-bit combinational ALU in the MIPS8 datapath.
- Adds shifts and an optional multi-cycle shift-add multiplier, plus carry/borrow.
- Computes signed overflow correctly from operand/result MSBs.
- Uses a start/done handshake so the control unit can stall on multi-cycle ops; sits between the register file read ports and the writeback mux.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/seq_alu_mul.sv | 48 ++++
 rtl/seq_alu.sv | 164 ++++++++++++++++
 tb/tb_seq_alu.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for seq_alu: function codes, FSM state encodings and flag bit ordering.
// The flag ordering is also used by the control-unit decode.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_SIGN  = 1;
  localparam int FLG_OVF   = 2;
  localparam int FLG_CARRY = 3;
  localparam int FLG_W     = 4;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative unsigned shift-add multiplier: one partial-product step per cycle, WIDTH steps.
// prod_next is the product after the current step, so the caller can capture it on the last step.
module seq_alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] prod_next
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   add;

  // lo_q holds the unconsumed multiplier bits; the shifted-out sum fills in from the top
  always_comb begin
    add       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    prod_next = {add, lo_q[WIDTH-1:1]};
    last      = (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      mcand_q <= a;
      hi_q    <= '0;
      lo_q    <= b;
      cnt_q   <= CW'(WIDTH - 1);
    end else if (step) begin
      {hi_q, lo_q} <= prod_next;
      cnt_q        <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with start/done handshake; single-cycle logic/arith/shift ops.
// Define SEQ_ALU_MUL_EN to add the multi-cycle MUL (func 8); otherwise func 8 is reserved.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             sign,
  output logic             ovf,
  output logic             carry
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               alu_carry;
  logic               single_go;
  logic [WIDTH-1:0]   result_q;
  logic               done_q;
  logic [FLG_W-1:0]   flags_q;

  always_comb begin
    sum       = {1'b0, op1} + {1'b0, op2};
    diff      = {1'b0, op1} - {1'b0, op2};
    shamt     = op2[SHW-1:0];
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_carry = 1'b0;
    case (func)
      ALU_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
      end
      ALU_SUB: begin
        // the extra top bit of the unsigned difference is the borrow
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
        alu_ovf   = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
      end
      ALU_AND: alu_res = op1 & op2;
      ALU_OR:  alu_res = op1 | op2;
      ALU_XOR: alu_res = op1 ^ op2;
      ALU_SLL: alu_res = op1 << shamt;
      ALU_SRL: alu_res = op1 >> shamt;
      ALU_SRA: alu_res = $unsigned($signed(op1) >>> shamt);
      default: ;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  state_t             state_q;
  state_t             state_d;
  logic               mul_load;
  logic               mul_step;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   result_hi_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && func == ALU_MUL) begin
          mul_load = 1'b1;
          state_d  = ST_MUL;
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready     = (state_q == ST_IDLE);
  assign single_go = ready && start && (func != ALU_MUL);
  assign result_hi = result_hi_q;

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .load      (mul_load),
    .step      (mul_step),
    .a         (op1),
    .b         (op2),
    .last      (mul_last),
    .prod_next (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      result_hi_q <= '0;
    end else if (single_go) begin
      result_hi_q <= '0;
    end else if (mul_step && mul_last) begin
      result_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
    end
  end
`else
  assign ready     = 1'b1;
  assign single_go = start;
  assign result_hi = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= FLG_W'(1) << FLG_ZERO;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (single_go) begin
        result_q           <= alu_res;
        flags_q[FLG_ZERO]  <= (alu_res == '0);
        flags_q[FLG_SIGN]  <= alu_res[WIDTH-1];
        flags_q[FLG_OVF]   <= alu_ovf;
        flags_q[FLG_CARRY] <= alu_carry;
        done_q             <= 1'b1;
      end
`ifdef SEQ_ALU_MUL_EN
      else if (mul_step && mul_last) begin
        result_q           <= mul_prod[WIDTH-1:0];
        flags_q[FLG_ZERO]  <= (mul_prod[WIDTH-1:0] == '0);
        flags_q[FLG_SIGN]  <= mul_prod[WIDTH-1];
        flags_q[FLG_OVF]   <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
        flags_q[FLG_CARRY] <= 1'b0;
        done_q             <= 1'b1;
      end
`endif
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign zero   = flags_q[FLG_ZERO];
  assign sign   = flags_q[FLG_SIGN];
  assign ovf    = flags_q[FLG_OVF];
  assign carry  = flags_q[FLG_CARRY];

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu (WIDTH=8); MUL vectors run only when SEQ_ALU_MUL_EN is defined.
module tb_seq_alu;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] func;
  logic [7:0] op1;
  logic [7:0] op2;
  logic       ready;
  logic       done;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic       zero;
  logic       sign;
  logic       ovf;
  logic       carry;

  int n_chk  = 0;
  int n_pass = 0;

  seq_alu #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .func      (func),
    .op1       (op1),
    .op2       (op2),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .zero      (zero),
    .sign      (sign),
    .ovf       (ovf),
    .carry     (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic [7:0] e_res, input logic [7:0] e_hi,
                           input logic e_z, input logic e_s, input logic e_o, input logic e_c);
    check({tag, ".result"}, 32'(result), 32'(e_res));
    check({tag, ".result_hi"}, 32'(result_hi), 32'(e_hi));
    check({tag, ".zero"}, 32'(zero), 32'(e_z));
    check({tag, ".sign"}, 32'(sign), 32'(e_s));
    check({tag, ".ovf"}, 32'(ovf), 32'(e_o));
    check({tag, ".carry"}, 32'(carry), 32'(e_c));
  endtask

  // one-cycle start pulse; returns #1 after the sampling edge
  task automatic issue(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1;
    func  = f;
    op1   = a;
    op2   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic single(input string tag, input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] e_res, input logic e_z, input logic e_s, input logic e_o,
                        input logic e_c);
    issue(f, a, b);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".ready"}, 32'(ready), 32'd1);
    check_out(tag, e_res, 8'h00, e_z, e_s, e_o, e_c);
  endtask

`ifdef SEQ_ALU_MUL_EN
  // launches MUL, counts cycles until done within a bounded budget
  task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b, output int lat);
    lat = 0;
    issue(4'd8, a, b);
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".done_seen"}, 32'(done), 32'd1);
  endtask
`endif

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    func  = 4'd0;
    op1   = 8'h00;
    op2   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst.done", 32'(done), 32'd0);
    check("rst.ready", 32'(ready), 32'd1);
    check_out("rst", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    single("add_7f_01", 4'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0);
    single("add_ff_01", 4'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    single("sub_00_01", 4'd1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
    single("sub_80_01", 4'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0);
    single("sub_05_05", 4'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    single("and",       4'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    single("or",        4'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    single("xor",       4'd4, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    single("sra_80_0b", 4'd7, 8'h80, 8'h0B, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
    single("sra_40_02", 4'd7, 8'h40, 8'h02, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    single("srl_80_03", 4'd6, 8'h80, 8'h03, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    single("sll_81_01", 4'd5, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    single("sll_01_0f", 4'd5, 8'h01, 8'h0F, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    single("rsv_f",     4'hF, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
`ifndef SEQ_ALU_MUL_EN
    single("rsv_8",     4'd8, 8'h03, 8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    // back-to-back starts, then hold
    @(negedge clk);
    start = 1'b1; func = 4'd0; op1 = 8'h01; op2 = 8'h02;
    @(posedge clk); #1;
    check("b2b1.done", 32'(done), 32'd1);
    check("b2b1.result", 32'(result), 32'h03);
    @(negedge clk);
    func = 4'd1; op1 = 8'h05; op2 = 8'h03;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b2.done", 32'(done), 32'd1);
    check("b2b2.result", 32'(result), 32'h02);
    @(posedge clk); #1;
    check("hold.done", 32'(done), 32'd0);
    check("hold.result", 32'(result), 32'h02);

`ifdef SEQ_ALU_MUL_EN
    begin
      int lat;
      int n_done;
      // MUL FF*FF with an ignored ADD start mid-operation
      issue(4'd8, 8'hFF, 8'hFF);
      check("mul1.ready_busy", 32'(ready), 32'd0);
      n_done = 0;
      lat = 1;
      for (int k = 1; k <= 8; k++) begin
        if (k == 3) begin
          @(negedge clk);
          start = 1'b1; func = 4'd0; op1 = 8'h01; op2 = 8'h01;
        end
        @(posedge clk); #1;
        start = 1'b0;
        lat++;
        if (done) n_done++;
        if (k == 4) check("mul1.ready_mid", 32'(ready), 32'd0);
      end
      check("mul1.latency_done", 32'(done), 32'd1);
      check("mul1.done_count", 32'(n_done), 32'd1);
      check("mul1.lat", 32'(lat), 32'd9);
      check_out("mul1", 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
      check("mul1.done_drop", 32'(done), 32'd0);
      check("mul1.ready_after", 32'(ready), 32'd1);

      // reset during cycle 4 of MUL 0F*11
      issue(4'd8, 8'h0F, 8'h11);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mulrst.done", 32'(done), 32'd0);
      check("mulrst.ready", 32'(ready), 32'd1);
      check_out("mulrst", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      n_done = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        if (done) n_done++;
      end
      check("mulrst.no_done", 32'(n_done), 32'd0);

      run_mul("mul2", 8'h0F, 8'h11, lat);
      check("mul2.lat", 32'(lat), 32'd9);
      check_out("mul2", 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

      // single op after MUL must clear result_hi
      single("add_after_mul", 4'd0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
